// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM stream reader: controller states and the
// default depth of the output FIFO.
package sram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/sram_stream_reader_stream_fifo.sv
// Small synchronous FIFO holding {tlast, tdata} entries for the stream reader.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is not reset; the consumer qualifies the head with empty.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Reads a contiguous block of SRAM words and streams them out as an AXI4-Stream
// master, using credit accounting so the FIFO never overflows under backpressure.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 9,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sram_ce,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] CREDIT_LIMIT = OW'(FIFO_DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  ce_last;
  logic                  inflight;
  logic                  inflight_last;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  pop;
  logic [OW-1:0]         outstanding;
  logic                  credit_ok;
  logic                  drain_done;

  assign o_sram_write  = 1'b0;
  assign o_sram_wdata  = '0;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[DATA_WIDTH];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Words issued but not yet handed off: queued, returning from SRAM, or being
  // issued right now. Uses registered terms only, so tready never reaches ce.
  assign outstanding = OW'(fifo_count) + OW'(inflight) + OW'(o_sram_ce);
  assign credit_ok   = (outstanding < CREDIT_LIMIT);

  // Looks ahead at this cycle's pop so done follows the final handshake directly.
  assign drain_done  = !inflight &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, i_sram_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_sram_ce     <= 1'b0;
      o_sram_addr   <= '0;
      next_addr     <= '0;
      remaining     <= '0;
      ce_last       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= o_sram_ce;
      inflight_last <= o_sram_ce && ce_last;
      o_done        <= 1'b0;
      o_sram_ce     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (i_len == '0) begin
              state <= ST_FINISH;
            end else begin
              // The FIFO is empty in IDLE, so the first read can go out at once.
              state       <= ST_READ;
              o_sram_ce   <= 1'b1;
              o_sram_addr <= i_base_addr;
              next_addr   <= i_base_addr + ADDR_WIDTH'(1);
              remaining   <= i_len - LEN_WIDTH'(1);
              ce_last     <= (i_len == LEN_WIDTH'(1));
            end
          end
        end

        ST_READ: begin
          if (remaining == '0) begin
            state <= ST_DRAIN;
          end else if (credit_ok) begin
            o_sram_ce   <= 1'b1;
            o_sram_addr <= next_addr;
            next_addr   <= next_addr + ADDR_WIDTH'(1);
            remaining   <= remaining - LEN_WIDTH'(1);
            ce_last     <= (remaining == LEN_WIDTH'(1));
          end
        end

        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: an SRAM model feeds the DUT and a
// scoreboard of expected beats is compared against every stream handshake.
module tb_sram_stream_reader;

  logic       i_clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [8:0] i_len;
  logic       o_busy;
  logic       o_done;
  logic       o_sram_ce;
  logic [7:0] o_sram_addr;
  logic       o_sram_write;
  logic [7:0] o_sram_wdata;
  logic [7:0] i_sram_rdata = '0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic [7:0] mem [256];
  beat_t      exp_q[$];
  logic [7:0] addr_log[$];

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int beats = 0;
  int dones = 0;
  int outstanding = 0;
  int first_ce_cycle = 0;
  int last_ce_cycle = 0;
  int last_hs_cycle = 0;
  int done_cycle = 0;
  logic       stalled = 1'b0;
  logic [7:0] held_data = '0;
  logic       held_last = 1'b0;

  always #5 i_clk = ~i_clk;

  sram_stream_reader dut (
    .i_clk         (i_clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .i_len         (i_len),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_sram_ce     (o_sram_ce),
    .o_sram_addr   (o_sram_addr),
    .o_sram_write  (o_sram_write),
    .o_sram_wdata  (o_sram_wdata),
    .i_sram_rdata  (i_sram_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // SRAM model with one cycle of read latency.
  always @(posedge i_clk) begin
    if (o_sram_ce) begin
      i_sram_rdata <= mem[o_sram_addr];
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    beat_t e;
    cycle++;
    if (rst) begin
      stalled     = 1'b0;
      outstanding = 0;
    end else begin
      if (stalled) begin
        total++;
        if (!m_axis_tvalid || m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
          bad++;
          $display("[TB] FAIL hold: tvalid=%b tdata=%h tlast=%b, required tvalid=1 tdata=%h tlast=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_data, held_last);
        end
      end
      if (o_sram_ce) begin
        if (addr_log.size() == 0) first_ce_cycle = cycle;
        last_ce_cycle = cycle;
        addr_log.push_back(o_sram_addr);
        outstanding++;
      end
      total++;
      if (outstanding > 4) begin
        bad++;
        $display("[TB] FAIL credit: outstanding=%0d, required <= 4", outstanding);
      end
      if (o_done) begin
        dones++;
        done_cycle = cycle;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        outstanding--;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL beat: got tdata=%h tlast=%b, required no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
            bad++;
            $display("[TB] FAIL beat: got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                     m_axis_tdata, m_axis_tlast, e.data, e.last);
          end
        end
        if (m_axis_tlast) last_hs_cycle = cycle;
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_last = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_expected(input logic [7:0] base, input int len);
    logic [7:0] a;
    beat_t e;
    a = base;
    for (int k = 0; k < len; k++) begin
      e.data = mem[a];
      e.last = (k == len - 1);
      exp_q.push_back(e);
      a = a + 8'd1;
    end
  endtask

  task automatic start_xfer(input logic [7:0] base, input logic [8:0] len);
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = len;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dones != d0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({o_busy, o_done, o_sram_ce, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
        o_sram_addr !== 8'h00 || m_axis_tdata !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_hold: busy=%b done=%b ce=%b addr=%h tvalid=%b tlast=%b tdata=%h, required all 0",
               o_busy, o_done, o_sram_ce, o_sram_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({o_busy, o_done, o_sram_ce, m_axis_tvalid, o_sram_write} !== 5'b0 || o_sram_wdata !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_idle: busy=%b done=%b ce=%b tvalid=%b write=%b wdata=%h, required all 0",
               o_busy, o_done, o_sram_ce, m_axis_tvalid, o_sram_write, o_sram_wdata);
    end
  endtask

  task automatic test_basic();
    int  d0, b0;
    bit  seen;
    logic exp_valid [3];
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    exp_valid[2] = 1'b1;
    d0 = dones;
    b0 = beats;
    addr_log.delete();
    m_axis_tready = 1'b1;
    push_expected(8'h10, 4);
    i_start     = 1'b1;
    i_base_addr = 8'h10;
    i_len       = 9'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      i_start = 1'b0;
      if (k == 0) begin
        total++;
        if (o_sram_ce !== 1'b1 || o_sram_addr !== 8'h10 || o_busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL basic_issue: ce=%b addr=%h busy=%b, required ce=1 addr=10 busy=1",
                   o_sram_ce, o_sram_addr, o_busy);
        end
      end
      total++;
      if (m_axis_tvalid !== exp_valid[k]) begin
        bad++;
        $display("[TB] FAIL basic_latency edge %0d: tvalid=%b, required %b", k, m_axis_tvalid, exp_valid[k]);
      end
    end
    wait_done(d0, 60, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL basic_done: no done within budget, required a done pulse");
    end
    total++;
    if (done_cycle - last_hs_cycle !== 2) begin
      bad++;
      $display("[TB] FAIL basic_done_timing: done %0d cycles after last beat sample, required 2",
               done_cycle - last_hs_cycle);
    end
    total++;
    if (addr_log.size() != 4 || last_ce_cycle - first_ce_cycle != 3) begin
      bad++;
      $display("[TB] FAIL basic_issue_count: issues=%0d span=%0d, required issues=4 span=3",
               addr_log.size(), last_ce_cycle - first_ce_cycle);
    end
    for (int k = 0; k < addr_log.size() && k < 4; k++) begin
      total++;
      if (addr_log[k] !== 8'(8'h10 + k)) begin
        bad++;
        $display("[TB] FAIL basic_addr %0d: addr=%h, required %h", k, addr_log[k], 8'(8'h10 + k));
      end
    end
    repeat (3) tick();
    total++;
    if (beats - b0 != 4 || dones - d0 != 1 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_totals: beats=%0d dones=%0d busy=%b, required beats=4 dones=1 busy=0",
               beats - b0, dones - d0, o_busy);
    end
  endtask

  task automatic test_wrap();
    int  d0, b0;
    bit  seen;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFE;
    exp_addr[1] = 8'hFF;
    exp_addr[2] = 8'h00;
    exp_addr[3] = 8'h01;
    d0 = dones;
    b0 = beats;
    addr_log.delete();
    push_expected(8'hFE, 4);
    start_xfer(8'hFE, 9'd4);
    wait_done(d0, 60, seen);
    total++;
    if (!seen || beats - b0 != 4 || addr_log.size() != 4) begin
      bad++;
      $display("[TB] FAIL wrap_totals: done=%b beats=%0d issues=%0d, required done=1 beats=4 issues=4",
               seen, beats - b0, addr_log.size());
    end
    for (int k = 0; k < addr_log.size() && k < 4; k++) begin
      total++;
      if (addr_log[k] !== exp_addr[k]) begin
        bad++;
        $display("[TB] FAIL wrap_addr %0d: addr=%h, required %h", k, addr_log[k], exp_addr[k]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    int   d0, b0;
    logic pattern [4];
    pattern[0] = 1'b1;
    pattern[1] = 1'b0;
    pattern[2] = 1'b0;
    pattern[3] = 1'b1;
    d0 = dones;
    b0 = beats;
    addr_log.delete();
    push_expected(8'h80, 8);
    start_xfer(8'h80, 9'd8);
    for (int i = 0; i < 300 && dones == d0; i++) begin
      m_axis_tready = (i >= 6 && i < 16) ? 1'b0 : pattern[i % 4];
      tick();
      if (i == 15) begin
        total++;
        if (o_sram_ce !== 1'b0 || m_axis_tvalid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL stall_credit: ce=%b tvalid=%b, required ce=0 tvalid=1", o_sram_ce, m_axis_tvalid);
        end
      end
    end
    m_axis_tready = 1'b1;
    total++;
    if (dones == d0) begin
      bad++;
      $display("[TB] FAIL stall_done: no done within budget, required a done pulse");
    end
    total++;
    if (beats - b0 != 8 || addr_log.size() != 8 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL stall_totals: beats=%0d issues=%0d pending=%0d, required beats=8 issues=8 pending=0",
               beats - b0, addr_log.size(), exp_q.size());
    end
    repeat (2) tick();
  endtask

  task automatic test_len_zero();
    int d0, b0, c0;
    d0 = dones;
    b0 = beats;
    c0 = addr_log.size();
    start_xfer(8'h55, 9'd0);
    total++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_sram_ce !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len0_start: busy=%b done=%b ce=%b, required busy=1 done=0 ce=0", o_busy, o_done, o_sram_ce);
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL len0_done: busy=%b done=%b, required busy=0 done=1", o_busy, o_done);
    end
    repeat (3) tick();
    total++;
    if (o_done !== 1'b0 || dones - d0 != 1 || beats != b0 || addr_log.size() != c0) begin
      bad++;
      $display("[TB] FAIL len0_quiet: done=%b dones=%0d beats=%0d issues=%0d, required done=0 dones=1 beats=0 issues=0",
               o_done, dones - d0, beats - b0, addr_log.size() - c0);
    end
  endtask

  task automatic test_restart_ignored();
    int d0, b0;
    bit seen;
    d0 = dones;
    b0 = beats;
    addr_log.delete();
    push_expected(8'h40, 6);
    start_xfer(8'h40, 9'd6);
    tick();
    start_xfer(8'hA0, 9'd2);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL restart_busy: busy=%b, required 1", o_busy);
    end
    wait_done(d0, 60, seen);
    total++;
    if (!seen || beats - b0 != 6 || addr_log.size() != 6 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL restart_totals: done=%b beats=%0d issues=%0d pending=%0d, required done=1 beats=6 issues=6 pending=0",
               seen, beats - b0, addr_log.size(), exp_q.size());
    end
    for (int k = 0; k < addr_log.size() && k < 6; k++) begin
      total++;
      if (addr_log[k] !== 8'(8'h40 + k)) begin
        bad++;
        $display("[TB] FAIL restart_addr %0d: addr=%h, required %h", k, addr_log[k], 8'(8'h40 + k));
      end
    end
    repeat (3) tick();
    total++;
    if (dones - d0 != 1 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL restart_single: dones=%0d busy=%b, required dones=1 busy=0", dones - d0, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0, b0;
    bit seen;
    bit reached;
    d0 = dones;
    b0 = beats;
    m_axis_tready = 1'b1;
    push_expected(8'h30, 8);
    start_xfer(8'h30, 9'd8);
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (beats - b0 >= 2) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!reached || m_axis_tvalid !== 1'b1 || m_axis_tdata !== mem[8'h32]) begin
      bad++;
      $display("[TB] FAIL midrst_beat3: reached=%b tvalid=%b tdata=%h, required reached=1 tvalid=1 tdata=%h",
               reached, m_axis_tvalid, m_axis_tdata, mem[8'h32]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_busy, o_done, o_sram_ce, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
        o_sram_addr !== 8'h00 || m_axis_tdata !== 8'h00) begin
      bad++;
      $display("[TB] FAIL midrst_async: busy=%b done=%b ce=%b addr=%h tvalid=%b tlast=%b tdata=%h, required all 0",
               o_busy, o_done, o_sram_ce, o_sram_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (dones != d0 || m_axis_tvalid !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_nodone: dones=%0d tvalid=%b busy=%b, required dones=0 tvalid=0 busy=0",
               dones - d0, m_axis_tvalid, o_busy);
    end
    b0 = beats;
    addr_log.delete();
    push_expected(8'h20, 2);
    start_xfer(8'h20, 9'd2);
    wait_done(d0, 60, seen);
    total++;
    if (!seen || beats - b0 != 2 || addr_log.size() != 2 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL midrst_restart: done=%b beats=%0d issues=%0d pending=%0d, required done=1 beats=2 issues=2 pending=0",
               seen, beats - b0, addr_log.size(), exp_q.size());
    end
    if (addr_log.size() == 2) begin
      total++;
      if (addr_log[0] !== 8'h20 || addr_log[1] !== 8'h21) begin
        bad++;
        $display("[TB] FAIL midrst_addr: addr=%h,%h, required 20,21", addr_log[0], addr_log[1]);
      end
    end
    repeat (2) tick();
  endtask

  initial begin
    rst           = 1'b1;
    i_start       = 1'b0;
    i_base_addr   = '0;
    i_len         = '0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
